rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_if.sv | 21 ++
 rtl/rom_loader.sv | 121 ++++++++++++
 tb/tb_rom_loader.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_if.sv
// HPS download port plus ROM write port of the program-ROM loader.
interface rom_loader_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        rom_we;
  logic [12:0] rom_addr;
  logic [15:0] rom_data;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    input  rom_we, rom_addr, rom_data
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_index, ioctl_addr, ioctl_dout,
    output rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/rom_loader.sv
// Packs HPS download bytes into big-endian 16-bit words for the CPU program ROM.
// ROM_LOADER_CHECKSUM_EN adds a running 16-bit sum of written words.
module rom_loader #(
  parameter int unsigned ROM_INDEX = 0,
  parameter int unsigned ROM_WORDS = 8192
) (
  input  logic        clk_sys,
  input  logic        reset,
  rom_loader_if.slave bus,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
`ifdef ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

  state_t      state, state_nx;
  logic        idx_hit, sel, byte_ok, in_range, enter_load;
  logic [7:0]  hi_q, hi_nx;
  logic [12:0] waddr_q, waddr_nx;
  logic        pend_q, pend_nx;
  logic        we_nx, err_nx;
  logic [12:0] addr_nx;
  logic [15:0] data_nx;

  assign idx_hit   = ({24'd0, bus.ioctl_index} == ROM_INDEX);
  assign sel       = bus.ioctl_download && idx_hit;
  assign byte_ok   = bus.ioctl_wr && idx_hit;
  assign in_range  = ({7'd0, bus.ioctl_addr} < (2 * ROM_WORDS));
  assign cpu_hold  = (state != S_DONE);
  assign load_done = (state == S_DONE);

  always_comb begin
    state_nx   = state;
    hi_nx      = hi_q;
    waddr_nx   = waddr_q;
    pend_nx    = pend_q;
    we_nx      = 1'b0;
    addr_nx    = bus.rom_addr;
    data_nx    = bus.rom_data;
    err_nx     = load_err;
    enter_load = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (sel) begin
          state_nx   = S_LOAD;
          enter_load = 1'b1;
          hi_nx      = '0;
          pend_nx    = 1'b0;
          err_nx     = 1'b0;
        end
      end
      S_LOAD: begin
        if (byte_ok) begin
          if (!in_range) begin
            err_nx = 1'b1;
          end else if (!bus.ioctl_addr[0]) begin
            hi_nx    = bus.ioctl_dout;
            waddr_nx = bus.ioctl_addr[13:1];
            pend_nx  = 1'b1;
          end else begin
            we_nx   = 1'b1;
            addr_nx = bus.ioctl_addr[13:1];
            data_nx = {(pend_q && waddr_q == bus.ioctl_addr[13:1]) ? hi_q : 8'h00,
                       bus.ioctl_dout};
            pend_nx = 1'b0;
          end
        end
        // The flush word is issued on the LOAD->FLUSH edge so its strobe lands
        // in FLUSH; it folds in an even byte arriving on the falling cycle.
        if (!bus.ioctl_download) begin
          state_nx = S_FLUSH;
          if (pend_nx) begin
            we_nx   = 1'b1;
            addr_nx = waddr_nx;
            data_nx = {hi_nx, 8'h00};
            pend_nx = 1'b0;
          end
        end
      end
      S_FLUSH: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= S_IDLE;
      hi_q         <= '0;
      waddr_q      <= '0;
      pend_q       <= 1'b0;
      load_err     <= 1'b0;
      bus.rom_we   <= 1'b0;
      bus.rom_addr <= '0;
      bus.rom_data <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      state        <= state_nx;
      hi_q         <= hi_nx;
      waddr_q      <= waddr_nx;
      pend_q       <= pend_nx;
      load_err     <= err_nx;
      bus.rom_we   <= we_nx;
      bus.rom_addr <= addr_nx;
      bus.rom_data <= data_nx;
`ifdef ROM_LOADER_CHECKSUM_EN
      if (enter_load)
        checksum <= '0;
      else if (we_nx)
        checksum <= checksum + data_nx;
`endif
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: expected ROM writes queued at stimulus time, checked on rom_we.
module tb_rom_loader;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic cpu_hold, load_done, load_err;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct { logic [12:0] addr; logic [15:0] data; } wr_t;
  wr_t sb[$];

  rom_loader_if bus();

  rom_loader #(.ROM_INDEX(0), .ROM_WORDS(8192)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
`ifdef ROM_LOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor
  logic prev_we = 1'b0;
  always @(negedge clk_sys) begin
    if (bus.rom_we === 1'b1) begin
      check("we_not_back_to_back", {31'd0, prev_we}, 32'd0);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_we got addr %0h data %0h expected no write", bus.rom_addr, bus.rom_data);
      end
      if (sb.size() != 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", {19'd0, bus.rom_addr}, {19'd0, e.addr});
        check("wr_data", {16'd0, bus.rom_data}, {16'd0, e.data});
      end
    end
    prev_we = bus.rom_we;
  end

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
  endtask

  task automatic send(input logic [24:0] a, input logic [7:0] d, input bit last);
    @(posedge clk_sys); #1;
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    if (last) bus.ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    bus.ioctl_wr = 1'b0;
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    bus.ioctl_download = 1'b0;
  endtask

  task automatic push(input logic [12:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (load_done === 1'b1) break;
    end
    check(tag, {31'd0, load_done}, 32'd1);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_done", {31'd0, load_done}, 32'd0);
    check("rst_err", {31'd0, load_err}, 32'd0);
    check("rst_we", {31'd0, bus.rom_we}, 32'd0);
    check("rst_addr", {19'd0, bus.rom_addr}, 32'd0);
    check("rst_data", {16'd0, bus.rom_data}, 32'd0);
    @(posedge clk_sys); #1 reset = 1'b0;

    // Foreign index: ignored entirely
    start_dl(8'd1);
    send(25'd0, 8'h12, 1'b0);
    send(25'd1, 8'h34, 1'b0);
    end_dl();
    repeat (3) @(negedge clk_sys);
    check("idx1_hold", {31'd0, cpu_hold}, 32'd1);
    check("idx1_done", {31'd0, load_done}, 32'd0);

    // Four-byte image
    start_dl(8'd0);
    send(25'd0, 8'h12, 1'b0);
    push(13'd0, 16'h1234);
    send(25'd1, 8'h34, 1'b0);
    send(25'd2, 8'h56, 1'b0);
    push(13'd1, 16'h5678);
    send(25'd3, 8'h78, 1'b0);
    end_dl();
    wait_done("four_done");
    check("hold_addr", {19'd0, bus.rom_addr}, 32'd1);
    check("hold_data", {16'd0, bus.rom_data}, 32'h5678);

    // Three-byte image; last byte arrives as download falls, flushed with low byte 00
    start_dl(8'd0);
    send(25'd0, 8'hAA, 1'b0);
    push(13'd0, 16'hAABB);
    send(25'd1, 8'hBB, 1'b0);
    push(13'd1, 16'hCC00);
    send(25'd2, 8'hCC, 1'b1);
    wait_done("three_done");

    // Out-of-range byte and an orphan odd byte
    start_dl(8'd0);
    send(25'h4000, 8'h99, 1'b0);
    push(13'd2, 16'h0077);
    send(25'd5, 8'h77, 1'b0);
    end_dl();
    wait_done("err_done");
    check("err_set", {31'd0, load_err}, 32'd1);
    repeat (2) @(negedge clk_sys);
    check("err_sticky", {31'd0, load_err}, 32'd1);

    // Reset midway through a load
    start_dl(8'd0);
    @(posedge clk_sys); #1;
    check("err_cleared", {31'd0, load_err}, 32'd0);
    send(25'd0, 8'h11, 1'b0);
    push(13'd0, 16'h1122);
    send(25'd1, 8'h22, 1'b0);
    @(posedge clk_sys); #1;
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("rst_mid_we", {31'd0, bus.rom_we}, 32'd0);
      check("rst_mid_hold", {31'd0, cpu_hold}, 32'd1);
    end
    @(posedge clk_sys); #1 reset = 1'b0;
    start_dl(8'd0);
    send(25'd0, 8'hA1, 1'b0);
    push(13'd0, 16'hA1B2);
    send(25'd1, 8'hB2, 1'b0);
    send(25'd2, 8'hC3, 1'b0);
    push(13'd1, 16'hC3D4);
    send(25'd3, 8'hD4, 1'b0);
    end_dl();
    wait_done("reload_done");

`ifdef ROM_LOADER_CHECKSUM_EN
    start_dl(8'd0);
    send(25'd0, 8'hFF, 1'b0);
    push(13'd0, 16'hFFFF);
    send(25'd1, 8'hFF, 1'b0);
    send(25'd2, 8'h00, 1'b0);
    push(13'd1, 16'h0002);
    send(25'd3, 8'h02, 1'b0);
    end_dl();
    wait_done("sum_done");
    check("checksum", {16'd0, checksum}, 32'h0001);
`endif

    check("sb_final_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
